pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic, parametrised inter-stage pipeline register for the ARM datapath.
//  Successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Adds a valid/ready handshake, a two-entry skid buffer so back-pressure never
//  drops a word, a synchronous flush that inserts a NOP bubble, and an
//  occupancy report. One instance sits between each pair of pipeline stages.
// PARAMETERS
//  WIDTH     32   payload bits (instruction word or packed control bundle)
//  NOP_VALUE 0    payload driven on reset, flush, and whenever out_valid=0
//  SKID      1    1 = two-entry skid buffer, registered in_ready;
//                 0 = single register, combinational in_ready (legacy LE-style stall)
// PORTS
//  clk        in   1      rising-edge clock
//  R          in   1      reset: synchronous, active-low
//  flush      in   1      synchronous kill of all held entries (branch taken)
//  in_valid   in   1      upstream offers in_data
//  in_data    in   WIDTH  upstream payload
//  in_ready   out  1      stage can accept this cycle
//  out_valid  out  1      out_data holds a live entry
//  out_data   out  WIDTH  oldest held payload; NOP_VALUE when out_valid=0
//  out_ready  in   1      downstream consumes this cycle
//  occupancy  out  2      held entries: 0, 1 or 2
// BEHAVIOUR
//  - accept  = in_valid & in_ready;  consume = out_valid & out_ready.
//  - Reset (R=0 at posedge): state=EMPTY, main=skid=NOP_VALUE, out_valid=0,
//    occupancy=0. In SKID=1, in_ready=0 during reset and 1 on the first cycle
//    after it. All outputs are registered except in_ready when SKID=0.
//  - Latency: in_data accepted at edge N appears on out_data after edge N.
//    Throughput is one word per cycle while out_ready=1.
//  - FSM (SKID=1): EMPTY, ONE, TWO. in_ready = (state!=TWO), registered.
//    EMPTY: accept -> ONE, main<=in_data.
//    ONE:   accept & !consume -> TWO, skid<=in_data;
//           consume & !accept -> EMPTY, main<=NOP_VALUE;
//           accept & consume -> ONE, main<=in_data; neither -> hold.
//    TWO:   consume -> ONE, main<=skid, skid<=NOP_VALUE; otherwise hold.
//  - SKID=0: states EMPTY and ONE only. in_ready = !out_valid | out_ready.
//  - FIFO order is strict: the skid word always leaves after the main word.
//  - out_data, out_valid and the held entries stay stable while out_ready=0.
//  - Flush has priority over accept and consume in the same cycle. On a flush:
//    the incoming word is dropped, state -> EMPTY, both entries <= NOP_VALUE,
//    and out_valid=0 on the next cycle.
//  - Reset has priority over flush. Reset mid-transfer discards all held data.
//  - in_data is ignored when in_valid=0. out_ready is a don't-care when out_valid=0.
// STRUCTURE
//  - Shared package pipe_pkg holds:
//      state localparams ST_EMPTY=2'b00, ST_ONE=2'b01, ST_TWO=2'b10
//      ARM_NOP=32'h0000_0000 (the default for NOP_VALUE)
//  - Sub-module pipe_skid_slot: a WIDTH-bit register with load enable and
//    synchronous clear-to-NOP_VALUE. It is instantiated twice (main and skid);
//    the skid instance is removed by generate when SKID=0.
//  - The FSM and handshake logic live in the top module.
// TESTING
//  1. Hold R=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0,
//     occupancy=0. SKID=1: in_ready=0 during reset, 1 on the next cycle.
//  2. Stream 0xE3A01005, 0xE2811001, 0xE0822001 with out_ready=1 ->
//     each appears one cycle after acceptance, occupancy stays 1,
//     no gaps in out_valid.
//  3. out_ready=0, offer 0xAAAA0001 then 0xAAAA0002 -> occupancy=2,
//     in_ready=0, out_data=0xAAAA0001 held; 0xAAAA0003 not accepted.
//     Release out_ready -> 0001 then 0002 in order.
//  4. Set occupancy=2 and raise flush together with in_valid=1 (0xBBBB0000)
//     -> next cycle occupancy=0, out_valid=0, out_data=0; 0xBBBB0000 never
//     emerges.
//  5. In state ONE with in_valid=out_ready=1 every cycle for 8 cycles ->
//     occupancy stays 1, all 8 words delivered in order.
//  6. SKID=0 build with out_ready=0 -> in_ready=0 in the same cycle;
//     out_ready=1 -> in_ready=1 combinationally. Single-word stall behaviour
//     matches the legacy LE register.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: FSM state
// encoding, the ARM NOP word and an occupancy decode helper.
package pipe_pkg;

  // Raw state encodings, kept visible for anything that logs or probes state.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  // ARM "andeq r0, r0, r0" encodes as all zeros; used as the bubble payload.
  localparam logic [31:0] ARM_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StOne   = ST_ONE,
    StTwo   = ST_TWO
  } pipe_state_e;

  // Number of live entries held in a given state.
  function automatic logic [1:0] state_occupancy(pipe_state_e st);
    case (st)
      StOne:   return 2'd1;
      StTwo:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register of the pipeline stage: load enable plus a synchronous
// clear that returns the slot to the bubble value. Reset also clears it.
module pipe_skid_slot #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             R,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Clear wins over load so a flush can never leave stale payload behind.
  always_ff @(posedge clk) begin
    if (!R || clr) begin
      data_q <= NOP_VALUE;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush-to-bubble and an
// occupancy report. The main slot always holds the oldest word, so out_data
// is simply the main slot.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(ARM_NOP),
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q, state_d;
  logic             out_valid_q;
  logic [1:0]       occupancy_q;
  logic             in_ready_q;

  logic             accept, consume;
  logic             main_load, main_clr, main_from_skid;
  logic             skid_load, skid_clr;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  // Without the skid buffer the stage can only take a word if its single
  // entry is empty or leaving this cycle (legacy stall behaviour).
  assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);

  assign accept  = in_valid && in_ready;
  assign consume = out_valid_q && out_ready;

  // Next-state and slot control decode; flush overrides any transfer.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = StEmpty;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            main_load = 1'b1;
          end
        end
        StOne: begin
          if (accept && !consume) begin
            // Only reachable with the skid buffer present.
            if (SKID) begin
              state_d   = StTwo;
              skid_load = 1'b1;
            end
          end else if (consume && !accept) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
          end else if (consume && accept) begin
            main_load = 1'b1;
          end
        end
        StTwo: begin
          if (consume) begin
            state_d        = StOne;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // FSM state plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!R) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != StEmpty);
      occupancy_q <= state_occupancy(state_d);
      in_ready_q  <= (state_d != StTwo);
    end
  end

  pipe_skid_slot #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_main_slot (
    .clk  (clk),
    .R    (R),
    .clr  (main_clr),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  if (SKID) begin : g_skid
    pipe_skid_slot #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_skid_slot (
      .clk  (clk),
      .R    (R),
      .clr  (skid_clr),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = NOP_VALUE;
    logic unused_skid_ctrl;
    assign unused_skid_ctrl = ^{skid_load, skid_clr};
  end

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Two instances (skid and legacy)
// share stimulus; a queue-based reference model predicts both.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model: FIFO contents of each instance, plus the expected
  // registered in_ready of the skid instance.
  logic [31:0] mq[$];
  logic [31:0] mq0[$];
  bit          exp_rdy = 1'b0;

  pipe_stage_skid #(.WIDTH(32), .NOP_VALUE(32'h0), .SKID(1'b1)) dut (
    .clk(clk), .R(rn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  pipe_stage_skid #(.WIDTH(32), .NOP_VALUE(32'h0), .SKID(1'b0)) dut0 (
    .clk(clk), .R(rn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_ready(out_ready), .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] head(input bit legacy);
    if (legacy) return (mq0.size() > 0) ? mq0[0] : 32'h0;
    return (mq.size() > 0) ? mq[0] : 32'h0;
  endfunction

  // Advance one clock edge, update the model from the applied inputs, then
  // settle 1 time unit past the edge for sampling.
  task automatic tick();
    bit acc, con, acc0, con0;
    @(posedge clk);
    if (!rn || flush) begin
      mq.delete();
      mq0.delete();
    end else begin
      acc  = in_valid && exp_rdy;
      con  = (mq.size() > 0) && out_ready;
      acc0 = in_valid && ((mq0.size() == 0) || out_ready);
      con0 = (mq0.size() > 0) && out_ready;
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (con0) void'(mq0.pop_front());
      if (acc0) mq0.push_back(in_data);
    end
    exp_rdy = rn && (mq.size() < 2);
    #1;
  endtask

  task automatic test_reset();
    rn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
    tick();
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_chk++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid0 got %b want 0", out_valid0); else n_pass++;
    rn = 1'b1; in_valid = 1'b0;
    tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", in_ready); else n_pass++;
    n_chk++; if (occupancy !== 2'd0) $display("FAIL reset_release_occ got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'hE3A01005; words[1] = 32'hE2811001; words[2] = 32'hE0822001;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      n_chk++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_chk++; if (out_data !== words[i]) $display("FAIL stream_data[%0d] got %h want %h", i, out_data, words[i]); else n_pass++;
      n_chk++; if (occupancy !== 2'd1) $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA0001;
    tick();
    n_chk++; if (occupancy !== 2'd1) $display("FAIL bp_occ1 got %0d want 1", occupancy); else n_pass++;
    in_data = 32'hAAAA0002;
    tick();
    n_chk++; if (occupancy !== 2'd2) $display("FAIL bp_occ2 got %0d want 2", occupancy); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_data !== 32'hAAAA0001) $display("FAIL bp_hold got %h want aaaa0001", out_data); else n_pass++;
    in_data = 32'hAAAA0003;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (out_data !== 32'hAAAA0001) $display("FAIL bp_stable[%0d] got %h want aaaa0001", i, out_data); else n_pass++;
      n_chk++; if (occupancy !== 2'd2) $display("FAIL bp_stable_occ[%0d] got %0d want 2", i, occupancy); else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_chk++; if (out_data !== 32'hAAAA0002) $display("FAIL bp_second got %h want aaaa0002", out_data); else n_pass++;
    n_chk++; if (occupancy !== 2'd1) $display("FAIL bp_release_occ got %0d want 1", occupancy); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release_rdy got %b want 1", in_ready); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0 (aaaa0003 leaked?)", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = $urandom; tick();
    in_data = $urandom; tick();
    n_chk++; if (occupancy !== 2'd2) $display("FAIL flush_setup_occ got %0d want 2", occupancy); else n_pass++;
    flush = 1'b1; in_data = 32'hBBBB0000; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (occupancy !== 2'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 32'h0) $display("FAIL flush_data got %h want 0", out_data); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0 || out_data === 32'hBBBB0000) $display("FAIL flush_after[%0d] got valid=%b data=%h want valid=0", i, out_valid, out_data); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    out_ready = 1'b1; in_valid = 1'b1; in_data = $urandom;
    tick();
    for (int i = 0; i < 8; i++) begin
      w = $urandom; in_data = w;
      tick();
      n_chk++; if (occupancy !== 2'd1) $display("FAIL b2b_occ[%0d] got %0d want 1", i, occupancy); else n_pass++;
      n_chk++; if (out_valid !== 1'b1 || out_data !== w) $display("FAIL b2b_data[%0d] got %b/%h want 1/%h", i, out_valid, out_data, w); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid0();
    logic [31:0] x1, x2, x3;
    x1 = $urandom; x2 = $urandom; x3 = $urandom;
    out_ready = 1'b0; in_valid = 1'b1; in_data = x1;
    tick();
    n_chk++; if (occupancy0 !== 2'd1 || out_data0 !== x1) $display("FAIL s0_load got %0d/%h want 1/%h", occupancy0, out_data0, x1); else n_pass++;
    n_chk++; if (in_ready0 !== 1'b0) $display("FAIL s0_stall_rdy got %b want 0", in_ready0); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready0 !== 1'b1) $display("FAIL s0_comb_rdy got %b want 1", in_ready0); else n_pass++;
    in_data = x2;
    tick();
    n_chk++; if (out_data0 !== x2 || occupancy0 !== 2'd1) $display("FAIL s0_pass got %h/%0d want %h/1", out_data0, occupancy0, x2); else n_pass++;
    out_ready = 1'b0; in_data = x3;
    #1;
    n_chk++; if (in_ready0 !== 1'b0) $display("FAIL s0_stall_rdy2 got %b want 0", in_ready0); else n_pass++;
    tick();
    n_chk++; if (out_data0 !== x2) $display("FAIL s0_hold got %h want %h", out_data0, x2); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_data0 !== x3) $display("FAIL s0_release got %h want %h", out_data0, x3); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0) $display("FAIL s0_empty got %b/%0d want 0/0", out_valid0, occupancy0); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rn        = ($urandom_range(63) != 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(2) != 0);
      tick();
      n_chk++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, mq.size() > 0); else n_pass++;
      n_chk++; if (out_data !== head(1'b0)) $display("FAIL rnd_data[%0d] got %h want %h", i, out_data, head(1'b0)); else n_pass++;
      n_chk++; if (occupancy !== 2'(mq.size())) $display("FAIL rnd_occ[%0d] got %0d want %0d", i, occupancy, mq.size()); else n_pass++;
      n_chk++; if (in_ready !== exp_rdy) $display("FAIL rnd_in_ready[%0d] got %b want %b", i, in_ready, exp_rdy); else n_pass++;
      n_chk++; if (out_valid0 !== (mq0.size() > 0)) $display("FAIL rnd_valid0[%0d] got %b want %b", i, out_valid0, mq0.size() > 0); else n_pass++;
      n_chk++; if (out_data0 !== head(1'b1)) $display("FAIL rnd_data0[%0d] got %h want %h", i, out_data0, head(1'b1)); else n_pass++;
      n_chk++; if (occupancy0 !== 2'(mq0.size())) $display("FAIL rnd_occ0[%0d] got %0d want %0d", i, occupancy0, mq0.size()); else n_pass++;
      n_chk++; if (in_ready0 !== ((mq0.size() == 0) || out_ready)) $display("FAIL rnd_in_ready0[%0d] got %b want %b", i, in_ready0, (mq0.size() == 0) || out_ready); else n_pass++;
    end
    rn = 1'b1; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_skid0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
